uart_tx: RTL and testbench

Serial UART transmitter, 8N1 by default with optional parity. It is the sending end of the board's serial link and the counterpart of the existing baud-tick/receive path. It accepts parallel bytes over a valid/ready handshake and shifts them out LSB-first on a single line. Bit timing comes from an internal restartable bit-period counter, so the frame is phase-aligned to the accepted byte.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/bit_timer.sv | 47 ++++
 rtl/uart_tx.sv | 168 ++++++++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, default baud timing and the
// parity helper. The receiver reuses this package.
package uart_pkg;

  // Transmit frame states; the encoding is explicit so that unused codes
  // (5..7) are well defined and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Board clock and line rate.
  localparam int unsigned CLK_HZ = 32'd100_000_000;
  localparam int unsigned BAUD   = 32'd9600;

  // Clock cycles per serial bit, rounded to nearest (100 MHz / 9600 -> 10417).
  localparam int unsigned DEFAULT_CLKS_PER_BIT = (CLK_HZ + (BAUD / 32'd2)) / BAUD;

  // Widest payload supported by either end of the link.
  localparam int unsigned MAX_DATA_BITS = 32'd8;

  // Parity over a zero-extended payload; zero padding does not change the
  // XOR, so narrower frames can share this helper. odd = 1 selects odd parity.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Restartable modulo-CLKS_PER_BIT counter. bit_tick pulses for one cycle on
// the terminal count so the frame FSM can advance exactly once per bit.
module bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLKS_PER_BIT - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart or idle forces zero, otherwise count and wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == TERM_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick only while a frame is running; the count is held at zero otherwise.
  assign bit_tick = run && (cnt_q == TERM_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte on a valid/ready handshake and sends
// start bit, LSB-first data, optional parity and 1 or 2 stop bits. The line
// output is a flop that follows the current state, so tx changes one cycle
// after the state does and can never glitch.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // >= 2
  parameter int unsigned DATA_BITS    = 32'd8,                // 5..8
  parameter int unsigned PARITY_EN    = 32'd0,                // 1 = parity bit
  parameter int unsigned PARITY_ODD   = 32'd0,                // 1 = odd parity
  parameter int unsigned STOP_BITS    = 32'd1                 // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned IDX_W  = $clog2(DATA_BITS + 32'd1);
  localparam int unsigned STOP_W = 32'd1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DATA_BITS - 32'd1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 32'd1);
  localparam logic              ODD_SEL   = (PARITY_ODD != 32'd0) ? 1'b1 : 1'b0;
  localparam tx_state_t         AFTER_DATA = (PARITY_EN != 32'd0) ? PARITY : STOP;

  tx_state_t            state_q,    state_d;
  logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic                 tx_q,       tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 busy_q,     busy_d;

  logic accept_s;
  logic run_s;
  logic bit_tick_s;

  // A byte is taken only in IDLE while ready is advertised.
  assign accept_s = (state_q == IDLE) && tx_ready_q && tx_valid;
  assign run_s    = (state_q != IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept_s),
    .run      (run_s),
    .bit_tick (bit_tick_s)
  );

  // Frame FSM: next state, shift/parity capture and the next line level.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept_s) begin
          state_d  = START;
          shift_d  = tx_data;
          parity_d = parity_bit(MAX_DATA_BITS'(tx_data), ODD_SEL);
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (bit_tick_s) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        tx_d = shift_q[0];
        if (bit_tick_s) begin
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d    = AFTER_DATA;
            stop_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1'b1);
          end
        end else begin
          state_d = DATA;
        end
      end

      PARITY: begin
        tx_d = parity_q;
        if (bit_tick_s) begin
          state_d    = STOP;
          stop_cnt_d = '0;
        end else begin
          state_d = PARITY;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_tick_s) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1'b1);
          end
        end else begin
          state_d = STOP;
        end
      end

      default: begin
        // Unused encodings fall back to an idle, high line.
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Handshake flags are registered from the next state so ready/busy line up
  // exactly with the state register and stay complementary.
  always_comb begin
    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State, datapath and output registers; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, even parity,
// odd parity and 7 data bits with 2 stop bits, all at 4 clocks per bit.
module tb_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;

  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic v0, v1, v2, v3;
  logic r0, r1, r2, r3;
  logic t0, t1, t2, t3;
  logic b0, b1, b2, b3;

  int total;
  int bad;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0), .tx_ready(r0), .tx(t0), .busy(b0));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1), .tx_ready(r1), .tx(t1), .busy(b1));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2), .tx_ready(r2), .tx(t2), .busy(b2));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_7n2 (.clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(v3), .tx_ready(r3), .tx(t3), .busy(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [7:0] data, input logic valid);
    case (idx)
      0: begin d0 = data;      v0 = valid; end
      1: begin d1 = data;      v1 = valid; end
      2: begin d2 = data;      v2 = valid; end
      3: begin d3 = data[6:0]; v3 = valid; end
      default: ;
    endcase
  endtask

  function automatic logic get_tx(input int idx);
    case (idx)
      0: return t0;
      1: return t1;
      2: return t2;
      3: return t3;
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic get_ready(input int idx);
    case (idx)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      default: return 1'bx;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return b0;
      1: return b1;
      2: return b2;
      3: return b3;
      default: return 1'bx;
    endcase
  endfunction

  // Expected line bits in transmit order: start, data LSB first, parity, stops.
  function automatic logic [15:0] frame_bits(input logic [7:0] data, input int db,
                                             input int pen, input int podd);
    logic [15:0] bits;
    logic        p;
    bits    = 16'hFFFF;
    bits[0] = 1'b0;
    p       = (podd != 0);
    for (int i = 0; i < db; i++) begin
      bits[1 + i] = data[i];
      p = p ^ data[i];
    end
    if (pen != 0) bits[1 + db] = p;
    return bits;
  endfunction

  // Sends one byte on instance idx and checks every cycle of the frame.
  // Starts and ends just after a falling clock edge.
  task automatic run_frame(input int idx, input logic [7:0] data, input int db,
                           input int pen, input int podd, input int sb,
                           output logic par_seen);
    logic [15:0] bits;
    int f;
    bits = frame_bits(data, db, pen, podd);
    f = (1 + db + pen + sb) * CPB;
    par_seen = 1'bx;
    chk($sformatf("u%0d_ready_pre", idx), get_ready(idx), 1'b1);
    drive(idx, data, 1'b1);
    @(posedge clk);
    #1;
    drive(idx, ~data, 1'b0);
    @(negedge clk);
    chk($sformatf("u%0d_tx_accept_cycle", idx), get_tx(idx), 1'b1);
    chk($sformatf("u%0d_busy_accept", idx), get_busy(idx), 1'b1);
    chk($sformatf("u%0d_ready_accept", idx), get_ready(idx), 1'b0);
    for (int k = 1; k <= f; k++) begin
      @(negedge clk);
      chk($sformatf("u%0d_d%0h_tx_k%0d", idx, data, k), get_tx(idx), bits[(k - 1) / CPB]);
      if (pen != 0 && (k - 1) / CPB == 1 + db && (k - 1) % CPB == CPB / 2)
        par_seen = get_tx(idx);
      if (k == f - 1) chk($sformatf("u%0d_ready_last", idx), get_ready(idx), 1'b0);
      if (k == f) begin
        chk($sformatf("u%0d_ready_end", idx), get_ready(idx), 1'b1);
        chk($sformatf("u%0d_busy_end", idx), get_busy(idx), 1'b0);
      end
    end
  endtask

  initial begin : main
    logic        par;
    logic [15:0] fa;
    logic [15:0] fb;
    int          first_ready;
    int          hi_cnt;
    logic        e;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 7'h00;
    v0 = 1'b0;  v1 = 1'b0;  v2 = 1'b0;  v3 = 1'b0;

    // Reset and idle line.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_in_reset", t0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", t0, 1'b1);
    chk("rst_ready", r0, 1'b1);
    chk("rst_busy", b0, 1'b0);
    chk("rst_all_ready", {r1, r2, r3}, 3'b111);
    hi_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if ({t0, t1, t2, t3} !== 4'b1111 || {r0, r1, r2, r3} !== 4'b1111) hi_cnt++;
    end
    chk("idle_100_cycles_bad", hi_cnt, 0);

    // 8N1 single byte.
    run_frame(0, 8'hA5, 8, 0, 0, 1, par);

    // Parity: even and odd on 0xA5, even on 0x01.
    run_frame(1, 8'hA5, 8, 1, 0, 1, par);
    chk("par_even_a5", par, 1'b0);
    run_frame(2, 8'hA5, 8, 1, 1, 1, par);
    chk("par_odd_a5", par, 1'b1);
    run_frame(1, 8'h01, 8, 1, 0, 1, par);
    chk("par_even_01", par, 1'b1);

    // Back-to-back with tx_valid held high: 0x55 then 0x0F.
    fa = frame_bits(8'h55, 8, 0, 0);
    fb = frame_bits(8'h0F, 8, 0, 0);
    first_ready = -1;
    drive(0, 8'h55, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 8'h0F, 1'b1);
    for (int k = 0; k <= 81; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        if (k <= 40)      e = fa[(k - 1) / CPB];
        else if (k == 41) e = 1'b1;
        else              e = fb[(k - 42) / CPB];
        chk($sformatf("b2b_tx_k%0d", k), t0, e);
      end
      if (r0 === 1'b1 && first_ready < 0) first_ready = k;
      if (k == 41) begin
        chk("b2b_busy_second", b0, 1'b1);
        drive(0, 8'hC3, 1'b0);
      end
    end
    chk("b2b_spacing", first_ready + 1, 41);
    chk("b2b_ready_end", r0, 1'b1);

    // 7 data bits, 2 stop bits.
    run_frame(3, 8'h7F, 7, 0, 0, 2, par);

    // Reset during data bit 3, then a fresh frame.
    drive(0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 8'hFF, 1'b0);
    repeat (18) @(negedge clk);
    chk("midrst_tx_before", t0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", t0, 1'b1);
    chk("midrst_ready", r0, 1'b1);
    chk("midrst_busy", b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_tx_after", t0, 1'b1);
    run_frame(0, 8'h3C, 8, 0, 0, 1, par);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
